// File: rtl/hdg_err_gen.sv
// Heading-error producer for the PID loop: saturated 10-bit error with a valid strobe,
// plus the forward-speed ramp FSM and a heading-settled detector, all stepped per sample.
`timescale 1ns/1ps
module hdg_err_gen #(
  parameter logic [8:0] SETTLE_THRESH = 9'd32,
  parameter logic [3:0] SETTLE_CNT    = 4'd8,
  parameter logic       FAST_SIM      = 1'b1,
  parameter logic [9:0] MAX_FRWRD     = 10'h2A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               moving,
  input  logic signed [11:0] dsrd_hdg,
  input  logic signed [11:0] heading,
  input  logic               hdg_vld,
  output logic        [9:0]  err_sat,
  output logic               err_vld,
  output logic        [9:0]  frwrd,
  output logic               settled
);

  typedef enum logic [1:0] {IDLE, RAMP, CRUISE, BRAKE} state_t;

  localparam logic [9:0] INC = FAST_SIM ? 10'h020 : 10'h004;
  localparam logic [9:0] DEC = {INC[8:0], 1'b0};

  state_t             state, state_next;
  logic        [9:0]  frwrd_next;
  logic        [3:0]  settle_cnt, settle_cnt_next;
  logic signed [11:0] err_raw;
  logic        [9:0]  sat_err, err_next, err_mag;
  logic        [10:0] ramp_sum;
  logic        [9:0]  brake_val;
  logic               on_hdg;

  // The 12-bit subtraction wraps by construction; there is deliberately no 13th bit.
  assign err_raw = heading - dsrd_hdg;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sat_err = err_raw[9:0];
    if (err_raw > 12'sd511)
      sat_err = 10'h1FF;
    else if (err_raw < -12'sd512)
      sat_err = 10'h200;
    err_next = moving ? sat_err : 10'h000;
  end

  // Two's-complement magnitude in 10 unsigned bits: 10'h200 maps to 512 without overflow.
  assign err_mag = err_next[9] ? (~err_next + 10'd1) : err_next;
  assign on_hdg  = moving && (err_mag <= {1'b0, SETTLE_THRESH});

  always_comb begin
    settle_cnt_next = 4'd0;
    if (on_hdg)
      settle_cnt_next = (settle_cnt == SETTLE_CNT) ? settle_cnt : settle_cnt + 4'd1;
  end

  // Ramp sum is one bit wider than frwrd so it can never wrap past 10'h3FF.
  assign ramp_sum  = {1'b0, frwrd} + {1'b0, INC};
  assign brake_val = (frwrd > DEC) ? (frwrd - DEC) : 10'h000;

  always_comb begin
    state_next = state;
    frwrd_next = frwrd;
    if (hdg_vld) begin
      unique case (state)
        IDLE: begin
          if (moving) begin
            state_next = RAMP;
            frwrd_next = INC;
          end
        end
        RAMP, CRUISE: begin
          if (moving) begin
            if (state == CRUISE || ramp_sum >= {1'b0, MAX_FRWRD}) begin
              state_next = CRUISE;
              frwrd_next = MAX_FRWRD;
            end else begin
              frwrd_next = ramp_sum[9:0];
            end
          end else begin
            state_next = (brake_val == 10'h000) ? IDLE : BRAKE;
            frwrd_next = brake_val;
          end
        end
        BRAKE: begin
          // Resuming motion re-enters RAMP from the current speed with no decrement.
          if (moving) begin
            state_next = RAMP;
          end else begin
            state_next = (brake_val == 10'h000) ? IDLE : BRAKE;
            frwrd_next = brake_val;
          end
        end
        default: begin
          state_next = IDLE;
          frwrd_next = 10'h000;
        end
      endcase
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      frwrd <= 10'h000;
    end else if (clr) begin
      state <= IDLE;
      frwrd <= 10'h000;
    end else begin
      state <= state_next;
      frwrd <= frwrd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat    <= 10'h000;
      err_vld    <= 1'b0;
      settle_cnt <= 4'd0;
      settled    <= 1'b0;
    end else if (clr) begin
      err_sat    <= 10'h000;
      err_vld    <= 1'b0;
      settle_cnt <= 4'd0;
      settled    <= 1'b0;
    end else begin
      err_vld <= hdg_vld;
      if (hdg_vld) begin
        err_sat    <= err_next;
        settle_cnt <= settle_cnt_next;
        settled    <= (settle_cnt_next == SETTLE_CNT);
      end
    end
  end

endmodule

// File: tb/tb_hdg_err_gen.sv
// Self-checking bench for hdg_err_gen: table vectors, directed multi-cycle sequences,
// and randomized traffic compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_hdg_err_gen;

  localparam int INC    = 32;
  localparam int MAXF   = 672;
  localparam int THRESH = 32;
  localparam int NSETT  = 8;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               moving;
  logic signed [11:0] dsrd_hdg;
  logic signed [11:0] heading;
  logic               hdg_vld;
  logic        [9:0]  err_sat;
  logic               err_vld;
  logic        [9:0]  frwrd;
  logic               settled;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_err, m_speed, m_run;
  bit m_vld, m_braking;

  hdg_err_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .moving   (moving),
    .dsrd_hdg (dsrd_hdg),
    .heading  (heading),
    .hdg_vld  (hdg_vld),
    .err_sat  (err_sat),
    .err_vld  (err_vld),
    .frwrd    (frwrd),
    .settled  (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit moving;
    int heading;
    int dsrd;
    int exp_err;
  } evec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_sat(input logic signed [11:0] h, input logic signed [11:0] d);
    logic signed [11:0] w;
    int r;
    w = h - d;
    r = int'(w);
    if (r > 511) return 511;
    if (r < -512) return -512;
    return r;
  endfunction

  task automatic model_reset();
    m_err = 0; m_speed = 0; m_run = 0; m_vld = 0; m_braking = 0;
  endtask

  task automatic model_edge();
    int e;
    if (clr) begin
      model_reset();
    end else if (hdg_vld) begin
      e = moving ? m_sat(heading, dsrd_hdg) : 0;
      m_err = e;
      m_vld = 1;
      if (moving) begin
        if (m_braking) m_braking = 0;
        else m_speed = (m_speed + INC > MAXF) ? MAXF : m_speed + INC;
      end else begin
        m_speed = (m_speed - 2 * INC < 0) ? 0 : m_speed - 2 * INC;
        m_braking = (m_speed != 0);
      end
      if (moving && ((e < 0) ? -e : e) <= THRESH) m_run++;
      else m_run = 0;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " err_sat"}, int'($signed(err_sat)), m_err);
    check({tag, " err_vld"}, int'(err_vld), int'(m_vld));
    check({tag, " frwrd"},   int'(frwrd), m_speed);
    check({tag, " settled"}, int'(settled), (m_run >= NSETT) ? 1 : 0);
  endtask

  task automatic do_clr();
    clr = 1'b1; hdg_vld = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic set_hdg(input int h, input int d);
    heading  = 12'(h);
    dsrd_hdg = 12'(d);
  endtask

  initial begin
    evec_t vecs[12];
    vecs[0]  = '{1'b1,   100,     0,  100};
    vecs[1]  = '{1'b1,  1000,     0,  511};
    vecs[2]  = '{1'b1, -1000,     0, -512};
    vecs[3]  = '{1'b1,  2047, -2048,   -1};
    vecs[4]  = '{1'b1,   511,     0,  511};
    vecs[5]  = '{1'b1,   512,     0,  511};
    vecs[6]  = '{1'b1,  -512,     0, -512};
    vecs[7]  = '{1'b1,  -513,     0, -512};
    vecs[8]  = '{1'b1,     0,     5,   -5};
    vecs[9]  = '{1'b1,     0, -2048, -512};
    vecs[10] = '{1'b0,   300,     0,    0};
    vecs[11] = '{1'b1,  -300,   200, -500};

    rst_n = 1'b0; clr = 1'b0; moving = 1'b0; hdg_vld = 1'b0;
    dsrd_hdg = '0; heading = '0;
    model_reset();
    #12;
    check("reset err_sat", int'(err_sat), 0);
    check("reset err_vld", int'(err_vld), 0);
    check("reset frwrd",   int'(frwrd), 0);
    check("reset settled", int'(settled), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First sample out of reset
    moving = 1'b1; set_hdg(100, 0); hdg_vld = 1'b1;
    tick();
    check("first err_sat", int'($signed(err_sat)), 100);
    check("first err_vld", int'(err_vld), 1);
    check("first frwrd",   int'(frwrd), 32);
    hdg_vld = 1'b0;
    tick();
    check("first err_vld drop", int'(err_vld), 0);
    check("first err_sat hold", int'($signed(err_sat)), 100);

    // Saturation / wrap table
    for (int i = 0; i < 12; i++) begin
      moving = vecs[i].moving;
      set_hdg(vecs[i].heading, vecs[i].dsrd);
      hdg_vld = 1'b1;
      tick();
      check($sformatf("vec%0d err_sat", i), int'($signed(err_sat)), vecs[i].exp_err);
      check($sformatf("vec%0d err_vld", i), int'(err_vld), 1);
      hdg_vld = 1'b0;
      tick();
      check($sformatf("vec%0d err_vld drop", i), int'(err_vld), 0);
    end

    // Ramp to ceiling, brake to zero, restart from idle
    do_clr();
    moving = 1'b1; set_hdg(0, 0); hdg_vld = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1)  check("ramp s1",  int'(frwrd), 32);
      if (i == 20) check("ramp s20", int'(frwrd), 640);
      if (i == 22) check("ramp s22", int'(frwrd), 672);
      if (i == 25) check("cruise hold", int'(frwrd), 672);
    end
    moving = 1'b0; set_hdg(200, 0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 1)  check("brake s1",  int'(frwrd), 608);
      if (i == 10) check("brake s10", int'(frwrd), 32);
      if (i == 11) check("brake s11", int'(frwrd), 0);
      if (i == 5)  check("brake err_sat", int'($signed(err_sat)), 0);
    end
    moving = 1'b1;
    tick();
    check("idle restart", int'(frwrd), 32);

    // Settled detector
    do_clr();
    moving = 1'b1; hdg_vld = 1'b1; set_hdg(20, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("settle s7", int'(settled), 0);
      if (i == 8) check("settle s8", int'(settled), 1);
    end
    set_hdg(40, 0);
    tick();
    check("settle off-heading", int'(settled), 0);
    set_hdg(32, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("settle thr s7", int'(settled), 0);
      if (i == 8) check("settle thr s8", int'(settled), 1);
    end
    set_hdg(0, 33);
    tick();
    check("settle -33", int'(settled), 0);

    // clr with hdg_vld mid-ramp
    do_clr();
    moving = 1'b1; hdg_vld = 1'b1; set_hdg(0, 0);
    for (int i = 0; i < 8; i++) tick();
    check("pre-clr frwrd",   int'(frwrd), 256);
    check("pre-clr settled", int'(settled), 1);
    clr = 1'b1; set_hdg(100, 0);
    tick();
    clr = 1'b0;
    check("clr frwrd",   int'(frwrd), 0);
    check("clr err_vld", int'(err_vld), 0);
    check("clr settled", int'(settled), 0);
    check("clr err_sat", int'($signed(err_sat)), 0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 9; i++) tick();
    check("pre-rst frwrd", int'(frwrd), 288);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async err_sat", int'(err_sat), 0);
    check("async err_vld", int'(err_vld), 0);
    check("async frwrd",   int'(frwrd), 0);
    check("async settled", int'(settled), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back samples
    moving = 1'b1; hdg_vld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_hdg(10 * i, 0);
      tick();
      check($sformatf("b2b%0d err_vld", i), int'(err_vld), 1);
      check($sformatf("b2b%0d err_sat", i), int'($signed(err_sat)), 10 * i);
    end
    hdg_vld = 1'b0;
    tick();
    check("b2b err_vld drop", int'(err_vld), 0);
    check("b2b err_sat hold", int'($signed(err_sat)), 40);

    // Randomized traffic against the reference model
    do_clr();
    moving = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) moving = ~moving;
      hdg_vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) dsrd_hdg = 12'($urandom);
      if ($urandom_range(0, 3) == 0)
        heading = 12'($urandom);
      else
        heading = dsrd_hdg + 12'(int'($urandom_range(0, 80)) - 40);
      tick();
      check_model($sformatf("rand%0d", i));
    end
    clr = 1'b0; hdg_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
